// File: rtl/present_pkg.sv
// Shared PRESENT definitions: S-box, round count, FSM states and key width.
// Key width follows the PRESENT_KEY128_EN macro (128-bit key when defined, 80-bit otherwise).
package present_pkg;

    localparam int ROUNDS_DEF = 31;

`ifdef PRESENT_KEY128_EN
    localparam int KEY_W = 128;
`else
    localparam int KEY_W = 80;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // PRESENT 4-bit S-box
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/present_round_ctrl_if.sv
// Block-in / ciphertext-out handshake bundle for the PRESENT engine.
// Key width tracks PRESENT_KEY128_EN through present_pkg.
interface present_round_ctrl_if;
    logic                          in_valid;
    logic                          in_ready;
    logic [63:0]                   in_data;
    logic [present_pkg::KEY_W-1:0] in_key;
    logic                          out_valid;
    logic                          out_ready;
    logic [63:0]                   out_data;

    // Producer/consumer side
    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Cipher engine side
    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/PresentNextStateFun.sv
// One PRESENT round: addRoundKey, sBoxLayer, pLayer. Purely combinational.
module PresentNextStateFun
    import present_pkg::*;
(
    input  logic [63:0] state,
    input  logic [63:0] round_key,
    output logic [63:0] next_state
);
    logic [63:0] keyed;
    logic [63:0] subst;

    assign keyed = state ^ round_key;

    // Sixteen parallel S-boxes, then bit i moves to (16*i) mod 63; bit 63 stays put
    for (genvar n = 0; n < 16; n++) begin : g_sbox
        assign subst[4*n +: 4] = sbox(keyed[4*n +: 4]);
    end

    for (genvar i = 0; i < 64; i++) begin : g_perm
        assign next_state[(i == 63) ? 63 : ((i * 16) % 63)] = subst[i];
    end
endmodule

// File: rtl/present_key_update.sv
// On-the-fly PRESENT key schedule step: rotate left 61, S-box the top nibble(s),
// XOR the round counter in. The 128-bit variant exists only under PRESENT_KEY128_EN.
module present_key_update
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [4:0]       round_idx,
    output logic [KEY_W-1:0] next_key
);
    logic [KEY_W-1:0] rot;

    assign rot = {key[KEY_W-62:0], key[KEY_W-1:KEY_W-61]};

`ifdef PRESENT_KEY128_EN
    // 128-bit schedule: two S-boxed nibbles, counter into bits 66:62
    always_comb begin
        next_key          = rot;
        next_key[127:124] = sbox(rot[127:124]);
        next_key[123:120] = sbox(rot[123:120]);
        next_key[66:62]   = rot[66:62] ^ round_idx;
    end
`else
    // 80-bit schedule: one S-boxed nibble, counter into bits 19:15
    always_comb begin
        next_key        = rot;
        next_key[79:76] = sbox(rot[79:76]);
        next_key[19:15] = rot[19:15] ^ round_idx;
    end
`endif
endmodule

// File: rtl/present_round_ctrl.sv
// Iterative PRESENT encryption core: one round per clock, 31 rounds, final key
// whitening applied combinationally while the result is held in DONE.
// PRESENT_KEY128_EN selects the 128-bit key schedule; default is 80-bit.
module present_round_ctrl
    import present_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    present_round_ctrl_if.slave  bus,
    output logic                 busy,
    output logic [4:0]           round_idx
);
    state_e            fsm_q, fsm_d;
    logic [63:0]       state_q;
    logic [KEY_W-1:0]  key_q;
    logic [63:0]       state_nxt;
    logic [KEY_W-1:0]  key_nxt;
    logic              last_round;

    assign last_round = (round_idx == 5'(ROUNDS));

    PresentNextStateFun u_round (
        .state      (state_q),
        .round_key  (key_q[KEY_W-1 -: 64]),
        .next_state (state_nxt)
    );

    present_key_update u_key (
        .key       (key_q),
        .round_idx (round_idx),
        .next_key  (key_nxt)
    );

    // Result is only meaningful in DONE; it is a pure function of the registers so it holds during stalls
    assign bus.out_data = state_q ^ key_q[KEY_W-1 -: 64];

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= IDLE;
        else        fsm_q <= fsm_d;
    end

    // Next state and handshake outputs
    always_comb begin
        fsm_d         = fsm_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        case (fsm_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
                if (bus.in_valid) fsm_d = RUN;
            end
            RUN: begin
                if (last_round) fsm_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
                busy  = 1'b0;
            end
        endcase
    end

    // Datapath: load on accept, iterate in RUN, clear the counter on output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= '0;
            key_q     <= '0;
            round_idx <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q   <= bus.in_data;
                        key_q     <= bus.in_key;
                        round_idx <= 5'd1;
                    end
                end
                RUN: begin
                    state_q <= state_nxt;
                    key_q   <= key_nxt;
                    // Counter parks at ROUNDS so DONE still reports the last round
                    if (!last_round) round_idx <= round_idx + 5'd1;
                end
                DONE: begin
                    if (bus.out_ready) round_idx <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_present_round_ctrl.sv
// Self-checking bench for present_round_ctrl: known-answer vectors, stall, back-to-back,
// mid-run reset and random blocks against a behavioural PRESENT model.
module tb_present_round_ctrl;
`ifdef PRESENT_KEY128_EN
    localparam int KW = 128;
`else
    localparam int KW = 80;
`endif
    // S(x) is nibble x of this word
    localparam logic [63:0] SBOX_TAB = 64'h21748FE3DA09B65C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [4:0] round_idx;
    int         n_checks = 0;
    int         n_fail = 0;

    present_round_ctrl_if bus ();

    present_round_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] s4(input logic [3:0] x);
        return SBOX_TAB[int'(x) * 4 +: 4];
    endfunction

    // Textbook PRESENT encryption: 31 rounds then whitening with the 32nd round key
    function automatic logic [63:0] model_enc(input logic [63:0] pt, input logic [KW-1:0] key);
        logic [63:0]   s, t;
        logic [KW-1:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[KW-1 -: 64];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = s4(s[4*n +: 4]);
            for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (i * 16) % 63] = t[i];
            k = (k << 61) | (k >> (KW - 61));
            k[KW-1 -: 4] = s4(k[KW-1 -: 4]);
`ifdef PRESENT_KEY128_EN
            k[123:120] = s4(k[123:120]);
            k[66:62]   = k[66:62] ^ 5'(r);
`else
            k[19:15]   = k[19:15] ^ 5'(r);
`endif
        end
        return s ^ k[KW-1 -: 64];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full block: accept, 31 rounds, optional output stall, handshake
    task automatic do_block(input logic [63:0] pt, input logic [KW-1:0] key,
                            input logic [63:0] exp, input bit hold, input int stall,
                            input string name);
        int cyc;
        bit seq_ok, stall_ok;
        bus.in_data   = pt;
        bus.in_key    = key;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        step();
        n_checks++;
        if (round_idx !== 5'd1 || busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: round_idx=%0d busy=%b in_ready=%b, required 1/1/0",
                     name, round_idx, busy, bus.in_ready);
        end
        if (!hold) bus.in_valid = 1'b0;
        cyc = 0;
        seq_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            if (!hold) begin
                bus.in_valid = 1'($urandom);
                bus.in_data  = {$urandom, $urandom};
                bus.in_key   = KW'({$urandom, $urandom, $urandom, $urandom});
            end
            step();
            cyc++;
            if (round_idx !== 5'((cyc < 31) ? cyc + 1 : 31)) seq_ok = 1'b0;
            if (bus.in_ready !== 1'b0) seq_ok = 1'b0;
        end
        n_checks++;
        if (cyc != 31) begin
            n_fail++;
            $display("FAIL %s latency: out_valid after %0d cycles, required 31", name, cyc);
        end
        n_checks++;
        if (!seq_ok) begin
            n_fail++;
            $display("FAIL %s round_idx sequence: last value %0d, required 2..31 with in_ready=0",
                     name, round_idx);
        end
        stall_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (bus.out_data !== exp || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1
                || round_idx !== 5'd31) stall_ok = 1'b0;
            bus.in_valid = 1'($urandom);
            step();
        end
        if (stall > 0) begin
            n_checks++;
            if (!stall_ok) begin
                n_fail++;
                $display("FAIL %s stall: out_data=%h in_ready=%b, required %h stable with in_ready=0",
                         name, bus.out_data, bus.in_ready, exp);
            end
        end
        bus.out_ready = 1'b1;
        n_checks++;
        if (bus.out_data !== exp || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ciphertext: got %h valid=%b, required %h valid=1",
                     name, bus.out_data, bus.out_valid, exp);
        end
        step();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || round_idx !== 5'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s handshake: in_ready=%b out_valid=%b round_idx=%0d busy=%b, required 1/0/0/0",
                     name, bus.in_ready, bus.out_valid, round_idx, busy);
        end
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 ||
            round_idx !== 5'd0 || bus.out_data !== 64'h0) begin
            n_fail++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b round_idx=%0d out_data=%h, required 1/0/0/0/0",
                     bus.in_ready, bus.out_valid, busy, round_idx, bus.out_data);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_kat();
`ifdef PRESENT_KEY128_EN
        do_block(64'h0, '0, 64'h96DB702A2E6900AF, 1'b0, 0, "kat128_zero");
`else
        logic [63:0] pts [4] = '{64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        logic [79:0] kys [4] = '{80'h0, {80{1'b1}}, 80'h0, {80{1'b1}}};
        logic [63:0] cts [4] = '{64'h5579C1387B228445, 64'hE72C46C0F5945049,
                                 64'hA112FFC72F68417B, 64'h3333DCD3213210D2};
        for (int i = 0; i < 3; i++) do_block(pts[i], kys[i], cts[i], 1'b0, 0, $sformatf("kat80_%0d", i));
`endif
    endtask

    task automatic test_stall();
`ifdef PRESENT_KEY128_EN
        do_block('1, '1, model_enc('1, '1), 1'b0, 10, "stall");
`else
        do_block(64'hFFFFFFFFFFFFFFFF, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b0, 10, "stall");
`endif
    endtask

    task automatic test_back_to_back();
        logic [63:0]   pt;
        logic [KW-1:0] key;
        for (int i = 0; i < 2; i++) begin
            pt  = {$urandom, $urandom};
            key = KW'({$urandom, $urandom, $urandom, $urandom});
            do_block(pt, key, model_enc(pt, key), 1'b1, 0, $sformatf("b2b_%0d", i));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int guard;
        bus.in_data   = {$urandom, $urandom};
        bus.in_key    = KW'({$urandom, $urandom, $urandom, $urandom});
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        guard = 0;
        while (round_idx !== 5'd12 && guard < 40) begin
            step();
            guard++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (guard >= 40 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 ||
            round_idx !== 5'd0 || bus.out_data !== 64'h0) begin
            n_fail++;
            $display("FAIL mid_run_reset: in_ready=%b out_valid=%b busy=%b round_idx=%0d out_data=%h, required 1/0/0/0/0",
                     bus.in_ready, bus.out_valid, busy, round_idx, bus.out_data);
        end
        step();
        rst_n = 1'b1;
        step();
        do_block(64'h0, '0, model_enc(64'h0, '0), 1'b0, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [63:0]   pt;
        logic [KW-1:0] key;
        for (int i = 0; i < 8; i++) begin
            pt  = {$urandom, $urandom};
            key = KW'({$urandom, $urandom, $urandom, $urandom});
            do_block(pt, key, model_enc(pt, key), 1'b0, int'($urandom_range(0, 3)),
                     $sformatf("rand_%0d", i));
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_kat();
        test_stall();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
